// File: rtl/jstk_spi_master_if.sv
// Bus bundle for the joystick SPI master: trigger, payload, SPI pins and
// transaction status. The master modport is the controller side; the slave
// modport is whatever drives the trigger/payload and plays the SPI slave.
interface jstk_spi_master_if;
    logic        SNDREC;
    logic [7:0]  CMD;
    logic [31:0] DIN;
    logic        MISO;
    logic        SS;
    logic        SCLK;
    logic        MOSI;
    logic        BUSY;
    logic        DONE;
    logic [39:0] DOUT;

    modport master (
        input  SNDREC, CMD, DIN, MISO,
        output SS, SCLK, MOSI, BUSY, DONE, DOUT
    );

    modport slave (
        output SNDREC, CMD, DIN, MISO,
        input  SS, SCLK, MOSI, BUSY, DONE, DOUT
    );
endinterface

// File: rtl/jstk_spi_master.sv
// SPI mode-0 master for a joystick module: one rising edge on SNDREC sends
// a command byte plus four parameter bytes and collects five reply bytes.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | SS high, waiting for a rising edge on SNDREC
//  SETUP | SS low, SCLK low, slave wake-up delay (SS_SETUP cycles)
//  XFER  | shifting one byte, CLK_DIV-cycle low half then high half
//  GAP   | SCLK idle low between bytes (BYTE_GAP cycles)
//  HOLD  | SCLK idle low after the last byte, then SS released
module jstk_spi_master #(
    parameter int CLK_DIV  = 6,
    parameter int SS_SETUP = 180,
    parameter int BYTE_GAP = 120
) (
    input  logic CLK,
    input  logic RST,
    jstk_spi_master_if.master bus
);
    localparam int T_MAX0 = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int T_MAX  = (T_MAX0 > CLK_DIV) ? T_MAX0 : CLK_DIV;
    localparam int TW     = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [2:0]    byte_cnt, byte_nxt;
    logic          sclk_q, sclk_nxt;
    logic [39:0]   tx, tx_nxt;
    logic [39:0]   rx, rx_nxt;
    logic [39:0]   dout_q, dout_nxt;
    logic          done_q, done_nxt;
    logic          prev;
    logic          start;

    // State register, datapath registers and the SNDREC edge-detect flop.
    // prev resets high so a trigger held high through reset is not an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sclk_q   <= 1'b0;
            tx       <= '0;
            rx       <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            prev     <= 1'b1;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
            sclk_q   <= sclk_nxt;
            tx       <= tx_nxt;
            rx       <= rx_nxt;
            dout_q   <= dout_nxt;
            done_q   <= done_nxt;
            prev     <= bus.SNDREC;
        end
    end

    // Next-state and datapath logic; the timer is a down-counter that is
    // reloaded with (length - 1) and acts on its terminal count of zero.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        bit_nxt   = bit_cnt;
        byte_nxt  = byte_cnt;
        sclk_nxt  = sclk_q;
        tx_nxt    = tx;
        rx_nxt    = rx;
        dout_nxt  = dout_q;
        done_nxt  = 1'b0;
        start     = bus.SNDREC & ~prev & (state == IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    timer_nxt = TW'(SS_SETUP - 1);
                    bit_nxt   = '0;
                    byte_nxt  = '0;
                    sclk_nxt  = 1'b0;
                    tx_nxt    = {bus.CMD, bus.DIN};
                    rx_nxt    = '0;
                end
            end
            SETUP: begin
                if (timer == '0) begin
                    state_nxt = XFER;
                    timer_nxt = TW'(CLK_DIV - 1);
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            XFER: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (!sclk_q) begin
                    // Rising SCLK edge: capture MISO, MOSI stays put.
                    sclk_nxt  = 1'b1;
                    rx_nxt    = {rx[38:0], bus.MISO};
                    timer_nxt = TW'(CLK_DIV - 1);
                end else begin
                    // Falling SCLK edge: bit done, present the next MOSI bit.
                    sclk_nxt  = 1'b0;
                    tx_nxt    = {tx[38:0], 1'b0};
                    timer_nxt = TW'(CLK_DIV - 1);
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = '0;
                        timer_nxt = TW'(BYTE_GAP - 1);
                        if (byte_cnt == 3'd4) begin
                            state_nxt = HOLD;
                        end else begin
                            byte_nxt  = byte_cnt + 1'b1;
                            state_nxt = GAP;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (timer == '0) begin
                    state_nxt = XFER;
                    timer_nxt = TW'(CLK_DIV - 1);
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            HOLD: begin
                if (timer == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    dout_nxt  = rx;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers or a state decode; tx is fully
    // shifted out by the end of a transaction, so MOSI idles low.
    assign bus.SS   = (state == IDLE);
    assign bus.BUSY = (state != IDLE);
    assign bus.SCLK = sclk_q;
    assign bus.MOSI = tx[39];
    assign bus.DONE = done_q;
    assign bus.DOUT = dout_q;
endmodule

// File: tb/tb_jstk_spi_master.sv
// Self-checking bench for jstk_spi_master: random transactions against a
// behavioural slave, scoreboarded DOUT/MOSI bytes and SPI timing checks.
module tb_jstk_spi_master;
    localparam int CLK_DIV  = 6;
    localparam int SS_SETUP = 180;
    localparam int BYTE_GAP = 120;
    localparam int SS_LOW   = SS_SETUP + 80 * CLK_DIV + 5 * BYTE_GAP;
    localparam int BYTE_LEN = 16 * CLK_DIV;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    jstk_spi_master_if bus ();

    jstk_spi_master #(
        .CLK_DIV (CLK_DIV),
        .SS_SETUP(SS_SETUP),
        .BYTE_GAP(BYTE_GAP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_dout_q[$];
    logic [39:0] exp_tx_q[$];
    int          done_cnt = 0;
    int          txn_cnt  = 0;

    logic        loopback = 1'b1;
    logic [39:0] slv_data = '0;
    logic [39:0] slv_sr   = '0;
    logic        slv_sclk_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Slave: first bit out when selected, next bit after each SCLK fall.
    assign bus.MISO = loopback ? bus.MOSI : slv_sr[39];
    initial forever begin
        @(negedge CLK);
        if (bus.SS) slv_sr = slv_data;
        else if (slv_sclk_d && !bus.SCLK) slv_sr = {slv_sr[38:0], 1'b0};
        slv_sclk_d = bus.SCLK;
    end

    // Scoreboard monitor: every DONE pops one expected DOUT; DOUT must not
    // move between DONE pulses.
    initial begin : done_mon
        logic [39:0] dout_d;
        dout_d = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                dout_d = bus.DOUT;
            end else begin
                if (bus.DONE) begin
                    done_cnt++;
                    if (exp_dout_q.size() == 0) flag("unexpected_done");
                    else check("dout", bus.DOUT, exp_dout_q.pop_front());
                end else begin
                    check("dout_hold", bus.DOUT, dout_d);
                end
                dout_d = bus.DOUT;
            end
        end
    end

    // Timing monitor: SS window length, SCLK half periods, gaps, MOSI bytes.
    initial begin : spi_mon
        logic        ss_d, sclk_d;
        int          ss_len, run, rises;
        logic [39:0] mosi_sr;
        ss_d = 1'b1; sclk_d = 1'b0; ss_len = 0; run = 0; rises = 0; mosi_sr = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                ss_d = 1'b1;
                sclk_d = 1'b0;
            end else begin
                if (!bus.SS) begin
                    if (ss_d) begin
                        ss_len = 0; run = 0; rises = 0; mosi_sr = '0; sclk_d = 1'b0;
                    end
                    ss_len++;
                    if (bus.SCLK != sclk_d) begin
                        if (bus.SCLK) begin
                            rises++;
                            if (rises == 1) check("first_rise_after_ss", run, SS_SETUP + CLK_DIV);
                            else if ((rises - 1) % 8 == 0) check("byte_gap_low", run, BYTE_GAP + CLK_DIV);
                            else check("low_half", run, CLK_DIV);
                            mosi_sr = {mosi_sr[38:0], bus.MOSI};
                        end else begin
                            check("high_half", run, CLK_DIV);
                        end
                        run = 1;
                    end else begin
                        run++;
                    end
                    sclk_d = bus.SCLK;
                end else if (!ss_d) begin
                    check("ss_low_len", ss_len, SS_LOW);
                    check("sclk_rises", rises, 40);
                    check("tail_low", run, BYTE_GAP);
                    check("done_at_ss_rise", bus.DONE, 1);
                    check("busy_at_ss_rise", bus.BUSY, 0);
                    if (exp_tx_q.size() == 0) flag("unexpected_ss_window");
                    else check("mosi_bytes", mosi_sr, exp_tx_q.pop_front());
                end
                ss_d = bus.SS;
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.DONE && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.DONE) flag("done_timeout");
        @(negedge CLK);
        check("done_one_cycle", bus.DONE, 0);
    endtask

    task automatic do_txn(input logic [7:0] c, input logic [31:0] d, input logic lb,
                          input logic [39:0] sd, input bit wait_end);
        @(negedge CLK);
        bus.CMD  = c;
        bus.DIN  = d;
        loopback = lb;
        slv_data = sd;
        @(negedge CLK);
        exp_tx_q.push_back({c, d});
        exp_dout_q.push_back(lb ? {c, d} : sd);
        txn_cnt++;
        bus.SNDREC = 1'b1;
        repeat (10) @(negedge CLK);
        bus.SNDREC = 1'b0;
        if (wait_end) wait_done();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ss"},   bus.SS,   1);
        check({tag, "_sclk"}, bus.SCLK, 0);
        check({tag, "_mosi"}, bus.MOSI, 0);
        check({tag, "_busy"}, bus.BUSY, 0);
        check({tag, "_done"}, bus.DONE, 0);
        check({tag, "_dout"}, bus.DOUT, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [7:0]  c;
        logic [31:0] d;
        logic [39:0] sd;
        int          n0;

        bus.SNDREC = 1'b1;
        bus.CMD    = '0;
        bus.DIN    = '0;
        RST        = 1'b1;
        repeat (5) @(negedge CLK);
        check_idle("reset");
        RST = 1'b0;

        // Trigger held high through reset release must not start anything.
        repeat (50) begin
            @(negedge CLK);
            check("held_high_no_start_busy", bus.BUSY, 0);
            check("held_high_no_start_ss", bus.SS, 1);
        end
        bus.SNDREC = 1'b0;

        repeat (100) begin
            @(negedge CLK);
            check_idle("idle");
        end

        do_txn(8'h84, 32'h1122_3344, 1'b1, 40'h0, 1'b1);
        do_txn(8'h84, 32'h1122_3344, 1'b0, 40'hA5_0102_03FF, 1'b1);

        for (int i = 0; i < 4; i++) begin
            c  = 8'($urandom);
            d  = $urandom;
            sd = {8'($urandom), $urandom};
            do_txn(c, d, 1'($urandom_range(0, 1)), sd, 1'b1);
            repeat ($urandom_range(0, 20)) @(negedge CLK);
        end

        // Re-trigger during byte 2, then keep the level high well past DONE.
        n0 = done_cnt;
        do_txn(8'h3C, 32'hDEAD_BEEF, 1'b1, 40'h0, 1'b0);
        repeat (SS_SETUP + BYTE_LEN + BYTE_GAP + 40 - 10) @(negedge CLK);
        check("busy_in_byte2", bus.BUSY, 1);
        bus.SNDREC = 1'b1;
        repeat (3000) @(negedge CLK);
        check("one_txn_per_edge", done_cnt, n0 + 1);
        check("idle_after_held_high", bus.BUSY, 0);
        bus.SNDREC = 1'b0;
        repeat (5) @(negedge CLK);

        // Abort with reset during byte 3.
        d = $urandom;
        do_txn(8'h5A, d, 1'b1, 40'h0, 1'b0);
        repeat (SS_SETUP + 2 * (BYTE_LEN + BYTE_GAP) + 50 - 10) @(negedge CLK);
        check("busy_in_byte3", bus.BUSY, 1);
        n0 = done_cnt;
        RST = 1'b1;
        void'(exp_dout_q.pop_back());
        void'(exp_tx_q.pop_back());
        txn_cnt--;
        @(negedge CLK);
        check("abort_ss", bus.SS, 1);
        check("abort_sclk", bus.SCLK, 0);
        check("abort_done", bus.DONE, 0);
        check("abort_dout", bus.DOUT, 0);
        check("abort_busy", bus.BUSY, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("abort_no_done", done_cnt, n0);

        do_txn(8'hC3, 32'h0BAD_F00D, 1'b0, 40'h13_5724_68AC, 1'b1);

        repeat (20) @(negedge CLK);
        check("dout_queue_empty", exp_dout_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        check("done_count", done_cnt, txn_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jstk_spi_master.md
JSTK_SPI_MASTER -- requirements
Module: jstk_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 6, CLK cycles per SCLK half-period (1 MHz SCLK from 12 MHz CLK).
REQ-002 Parameter SS_SETUP, default 180, CLK cycles from SS falling to the first SCLK low half-period (15 us).
REQ-003 Parameter BYTE_GAP, default 120, CLK cycles of idle SCLK after each byte, including after the last byte (10 us).
REQ-004 CLK  input  1  12 MHz system clock; all logic on posedge CLK.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 SNDREC  input  1  transaction trigger (10 Hz square wave); a rising edge starts one transaction.
REQ-007 CMD  input  8  command byte; latched at start.
REQ-008 DIN  input  32  parameter bytes; latched at start.
REQ-009 MISO  input  1  serial data from the slave.
REQ-010 SS  output  1  active-low slave select.
REQ-011 SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-012 MOSI  output  1  serial data to the slave, MSB first.
REQ-013 BUSY  output  1  high while a transaction is in progress.
REQ-014 DONE  output  1  one-cycle pulse at transaction end.
REQ-015 DOUT  output  40  the five received bytes; first received byte is in DOUT[39:32].

Function
REQ-016 SNDREC SHALL be registered into a previous-value flop; start = SNDREC & ~prev & state==IDLE.
REQ-017 Rising edges on SNDREC while BUSY=1 SHALL be ignored; a level held high SHALL start exactly one transaction.
REQ-018 On start, the block SHALL latch tx[39:0] = {CMD, DIN}; bytes are sent CMD, DIN[31:24], DIN[23:16], DIN[15:8], DIN[7:0].
REQ-019 The FSM states SHALL be IDLE -> SETUP -> XFER -> (GAP -> XFER)x4 -> HOLD -> IDLE.
REQ-020 SS SHALL go low and BUSY high on the cycle after start is detected; SETUP SHALL last SS_SETUP cycles with SCLK=0.
REQ-021 In XFER, each bit SHALL be a CLK_DIV-cycle SCLK-low half, then a CLK_DIV-cycle SCLK-high half; MOSI SHALL be valid for the whole bit, changing only while SCLK is low.
REQ-022 MISO SHALL be sampled on the CLK edge at which SCLK transitions 0->1 and shifted into rx, LSB in.
REQ-023 After 8 bits, if fewer than 5 bytes are done, the FSM SHALL enter GAP for BYTE_GAP cycles (SCLK=0, SS=0), then XFER.
REQ-024 After the 5th byte, HOLD SHALL keep SS=0, SCLK=0 for BYTE_GAP cycles.
REQ-025 SS SHALL be low for exactly SS_SETUP + 80*CLK_DIV + 5*BYTE_GAP cycles (1260 at defaults).
REQ-026 On the cycle SS returns high: DOUT <= rx, DONE=1 for that one cycle, BUSY=0, and the FSM SHALL return to IDLE.
REQ-027 DOUT SHALL hold its value between transactions and change only at DONE.
REQ-028 Bit and byte counters SHALL be sized for their parameters with no wrap before terminal count; the timer SHALL be wide enough for max(SS_SETUP, BYTE_GAP, CLK_DIV).
REQ-029 A new start SHALL be accepted on the cycle after DONE at the earliest.

Reset
REQ-030 While RST=1: SS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, DOUT=0, FSM=IDLE, counters=0, prev=1.
REQ-031 Because prev resets to 1, an SNDREC held high through reset release SHALL NOT start a transaction.
REQ-032 RST asserted mid-transaction SHALL abort it: SS=1 and SCLK=0 on the next edge, no DONE pulse, DOUT=0.

Verification
REQ-033 Reset, then SNDREC=0 for 100 cycles -> SS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, DOUT=0 throughout.
REQ-034 CMD=0x84, DIN=0x11223344, MISO looped to MOSI, one SNDREC edge -> SS low 1260 cycles, 40 SCLK pulses, a single DONE, DOUT=0x8411223344.
REQ-035 Timing check at defaults -> first SCLK rise 186 cycles after SS falls; 120 SCLK-low cycles between bytes; 6-cycle high and low halves.
REQ-036 Slave model returns 0xA5,0x01,0x02,0x03,0xFF -> DOUT=0xA5010203FF; MOSI bytes observed as 0x84,0x11,0x22,0x33,0x44.
REQ-037 Second SNDREC edge during byte 2, and SNDREC held high 3000 cycles -> exactly one transaction per rising edge outside BUSY.
REQ-038 RST pulse during byte 3 -> SS=1, SCLK=0 next cycle, no DONE, DOUT=0; next SNDREC edge completes a normal transaction.
